// File: rtl/frame_overlap_discard.sv
// frame_overlap_discard: strips the repeated overlap head from each framed block and checks framing
module frame_overlap_discard #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 256,
  parameter int OVERLAP   = 52
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  input  logic              data_in_last,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic              data_out_last,
  output logic [15:0]       frame_cnt,
  output logic              frame_err,
  output logic              sync_lost
);
  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] OV_LIM   = CW'(OVERLAP);
  localparam logic [CW-1:0] OV_END   = CW'(OVERLAP == 0 ? 0 : OVERLAP - 1);
  typedef enum logic [2:0] {IDLE, FIRST, DISCARD, KEEP, RESYNC} state_t;
  state_t            state_q;
  logic [CW-1:0]     in_cnt_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q, last_q, err_q, sync_q;
  logic [15:0]       cnt_q;
  logic              active, is_end, acc, pass, good_end, err;
  state_t            after_end;
  always_comb begin
    active    = state_q == FIRST || state_q == DISCARD || state_q == KEEP;
    is_end    = in_cnt_q == LAST_IDX;
    acc       = data_in_valid && active;
    pass      = acc && (state_q != DISCARD || in_cnt_q >= OV_LIM);
    good_end  = acc && data_in_last && is_end;
    err       = acc && (data_in_last != is_end);
    after_end = OVERLAP == 0 ? KEEP : DISCARD;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      in_cnt_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
      sync_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      valid_q <= pass;
      last_q  <= pass && good_end;
      err_q   <= err;
      if (pass) data_q <= data_in;
      if (good_end) cnt_q <= cnt_q + 16'd1;
      if (state_q == IDLE) begin
        if (start) begin
          state_q  <= FIRST;
          in_cnt_q <= '0;
        end
      end else if (state_q == RESYNC) begin
        if (data_in_valid && data_in_last) begin
          state_q  <= after_end;
          in_cnt_q <= '0;
          sync_q   <= 1'b0;
        end else if (data_in_valid) begin
          in_cnt_q <= is_end ? '0 : in_cnt_q + 1'b1;
        end
      end else if (data_in_valid) begin
        // any last (early or correct) restarts an overlapped frame; a missing last loses sync
        if (data_in_last) begin
          state_q  <= after_end;
          in_cnt_q <= '0;
        end else if (is_end) begin
          state_q  <= RESYNC;
          in_cnt_q <= '0;
          sync_q   <= 1'b1;
        end else begin
          in_cnt_q <= in_cnt_q + 1'b1;
          if (state_q == DISCARD && OVERLAP != 0 && in_cnt_q == OV_END) state_q <= KEEP;
        end
      end
    end
  end
  assign data_out       = data_q;
  assign data_out_valid = valid_q;
  assign data_out_last  = last_q;
  assign frame_cnt      = cnt_q;
  assign frame_err      = err_q;
  assign sync_lost      = sync_q;
endmodule
